avs_hram_burst_tester: RTL and testbench
========================================

Name: avs_hram_burst_tester

Overview:
- Avalon-MM burst master that sits directly upstream of the HyperRAM Avalon-to-HyperBus converter and drives its 16-bit burst slave port.
- Writes a programmable number of bursts of a generated data pattern, then reads the same region back and compares every beat.
- Reports pass/fail, error count and first failing address.
- Serves as the on-chip self-test driver for HyperRAM bring-up.

Parameters:
- ADDR_W, 32, Avalon byte-address width.
- DATA_W, 16, data width; each beat advances the address by DATA_W/8 bytes.
- BURST_W, 11, burstcount width; maximum legal burst length is 1024.
- CNT_W, 16, width of the burst counter and the error counter.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; accepted only in IDLE or DONE.
- cfg_base_addr  in  ADDR_W  byte start address; bit 0 is ignored and forced to 0.
- cfg_burst_len  in  BURST_W  beats per burst; 0 is treated as 1; values above 1024 are clamped to 1024.
- cfg_num_bursts  in  CNT_W  number of bursts.
- cfg_seed  in  DATA_W  pattern seed.
- avm_address  out  ADDR_W  burst start address.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  DATA_W  write data.
- avm_burstcount  out  BURST_W  burst length.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  DATA_W  read data.
- avm_readdatavalid  in  1  read beat valid.
- busy  out  1  test in progress.
- done  out  1  held high from test end until the next start.
- pass  out  1  valid while done is high; 1 means zero mismatches.
- error_count  out  CNT_W  mismatch count; saturates at all-ones.
- first_err_addr  out  ADDR_W  byte address of the first mismatch.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Config capture: cfg_* inputs are sampled on the start cycle.
- Start handling: start is ignored while busy. Start in DONE clears done, pass, error_count and first_err_addr, then begins a new test.
- cfg_num_bursts = 0: go straight to DONE next cycle with pass = 1.
- States: IDLE -> WR_BURST -> (next burst) WR_BURST | RD_CMD -> RD_DATA -> RD_CMD | DONE.
- WR_BURST, command:
  - avm_write is held high for all cfg_burst_len beats.
  - avm_address and avm_burstcount are driven constant for the whole burst.
  - A beat is accepted on avm_write & !avm_waitrequest; avm_writedata advances to the next pattern word only on acceptance.
  - All outputs hold stable while avm_waitrequest = 1.
- WR_BURST, completion: after the last beat, the address advances by 2*cfg_burst_len (mod 2^ADDR_W). The next burst starts the following cycle; after the final burst the state moves to RD_CMD.
- Read setup: on entering RD_CMD the address returns to the base and the pattern generator is re-seeded.
- RD_CMD: avm_read = 1 with address and burstcount held until !avm_waitrequest. avm_read drops the cycle after acceptance.
- RD_DATA:
  - Every avm_readdatavalid beat is compared with the next expected pattern word.
  - On mismatch, error_count increments (saturating). On the first mismatch of the test, first_err_addr records that beat's byte address.
  - After cfg_burst_len beats: go to RD_CMD for the next burst, or to DONE after the final burst.
  - Exactly one read burst is outstanding at any time.
- avm_read and avm_write are never high in the same cycle.
- DONE: busy = 0, done = 1, pass = (error_count == 0). The state is held until start.
- Address wrap: crossing 2^ADDR_W wraps silently; a burst is never split.
- Reset mid-operation: asynchronous return to IDLE. The bus request drops immediately; outstanding read data is discarded.
- Incrementing pattern (default): word i of the test = cfg_seed + i (mod 2^DATA_W).
- Latency: first avm_write is asserted the cycle after start.

Optional Feature:
- Macro: HRAM_TESTER_LFSR_EN.
- Defined: the pattern is a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1. It is seeded with cfg_seed (seed 0 is replaced by 16'hACE1) and advanced once per accepted or compared beat. Word 0 is the seed itself.
- Undefined: the incrementing pattern described under Behaviour.

Decomposition:
- Package hram_tester_pkg:
  - state enum;
  - LFSR tap constant 16'hB400;
  - default seed 16'hACE1;
  - MAX_BURST = 1024.
- Sub-module hram_pattern_gen: holds the seed, generates the next word on an advance strobe, and has a synchronous reload input. One instance is shared by the write and read phases.

Test Plan:
- Ideal slave, base 0x0000_0100, len 4, 2 bursts, seed 0x1000:
  - writes 0x1000..0x1007 at addresses 0x100 and 0x108;
  - reads back the same;
  - done = 1, pass = 1, error_count = 0.
- Random waitrequest (50%) on the writes: every writedata word is held until accepted; the write sequence is unchanged; pass = 1.
- Slave corrupts read beat 5 (addr base+10) of len 8, 1 burst: error_count = 1, first_err_addr = base+0xA, pass = 0.
- cfg_num_bursts = 0: done is asserted 1 cycle after start with pass = 1 and no bus activity.
- cfg_burst_len = 0, cfg_num_bursts = 3: three 1-beat bursts with avm_burstcount = 1.
- Reset asserted in RD_DATA mid-burst: all outputs return to 0 immediately. A subsequent start reruns cleanly with pass = 1.
- With HRAM_TESTER_LFSR_EN defined: seed 0 produces first write word 0xACE1.

Source files
------------

// File: rtl/hram_tester_pkg.sv
// Shared types and constants for the HyperRAM burst self-test master.
package hram_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_BURST,
    ST_RD_CMD,
    ST_RD_DATA,
    ST_DONE
  } state_e;

  // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  localparam int          MAX_BURST         = 1024;

endpackage

// File: rtl/hram_pattern_gen.sv
// Test-pattern generator shared by the write and read-back phases.
// HRAM_TESTER_LFSR_EN selects a 16-bit Galois LFSR instead of an incrementing count.
module hram_pattern_gen
  import hram_tester_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         seed_load_i,
  input  logic [W-1:0] seed_i,
  input  logic         reload_i,
  input  logic         advance_i,
  output logic [W-1:0] word_o
);

  logic [W-1:0] seed_q;
  logic [W-1:0] word_q;
  logic [W-1:0] first_word;
  logic [W-1:0] next_word;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
`ifdef HRAM_TESTER_LFSR_EN
    first_word = (seed_i == '0) ? W'(LFSR_DEFAULT_SEED) : seed_i;
    next_word  = (word_q >> 1) ^ (word_q[0] ? W'(LFSR_TAPS) : '0);
`else
    first_word = seed_i;
    next_word  = word_q + W'(1);
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q <= '0;
      word_q <= '0;
    end else if (seed_load_i) begin
      seed_q <= first_word;
      word_q <= first_word;
    end else if (reload_i) begin
      word_q <= seed_q;
    end else if (advance_i) begin
      word_q <= next_word;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/avs_hram_burst_tester.sv
// Avalon-MM burst master that writes a pattern to HyperRAM, reads it back and compares.
// Pattern is incrementing by default; HRAM_TESTER_LFSR_EN switches to the LFSR pattern.
module avs_hram_burst_tester
  import hram_tester_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 16,
  parameter int BURST_W = 11,
  parameter int CNT_W   = 16
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  cfg_base_addr,
  input  logic [BURST_W-1:0] cfg_burst_len,
  input  logic [CNT_W-1:0]   cfg_num_bursts,
  input  logic [DATA_W-1:0]  cfg_seed,
  output logic [ADDR_W-1:0]  avm_address,
  output logic               avm_read,
  output logic               avm_write,
  output logic [DATA_W-1:0]  avm_writedata,
  output logic [BURST_W-1:0] avm_burstcount,
  input  logic               avm_waitrequest,
  input  logic [DATA_W-1:0]  avm_readdata,
  input  logic               avm_readdatavalid,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   error_count,
  output logic [ADDR_W-1:0]  first_err_addr
);

  localparam int BEAT_BYTES = DATA_W / 8;

  state_e             state_q;
  logic [ADDR_W-1:0]  base_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  first_err_q;
  logic [BURST_W-1:0] len_q;
  logic [BURST_W-1:0] beat_q;
  logic [CNT_W-1:0]   nbursts_q;
  logic [CNT_W-1:0]   burst_q;
  logic [CNT_W-1:0]   err_q;
  logic [CNT_W-1:0]   err_d;
  logic               write_q;
  logic               read_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;

  logic               start_acc;
  logic               wr_acc;
  logic               rd_acc;
  logic               rd_beat;
  logic               last_beat;
  logic               last_burst;
  logic               mismatch;
  logic [BURST_W-1:0] len_eff;
  logic [ADDR_W-1:0]  base_eff;
  logic [ADDR_W-1:0]  burst_bytes;
  logic [ADDR_W-1:0]  beat_addr;
  logic [DATA_W-1:0]  pat_word;

  always_comb begin
    start_acc   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    wr_acc      = (state_q == ST_WR_BURST) && write_q && !avm_waitrequest;
    rd_acc      = (state_q == ST_RD_CMD) && read_q && !avm_waitrequest;
    rd_beat     = (state_q == ST_RD_DATA) && avm_readdatavalid;
    last_beat   = (beat_q == len_q - BURST_W'(1));
    last_burst  = (burst_q == nbursts_q - CNT_W'(1));
    mismatch    = rd_beat && (avm_readdata != pat_word);
    burst_bytes = ADDR_W'(len_q) * ADDR_W'(BEAT_BYTES);
    beat_addr   = addr_q + ADDR_W'(beat_q) * ADDR_W'(BEAT_BYTES);
    base_eff    = cfg_base_addr & ~ADDR_W'(1);

    err_d = err_q;
    if (mismatch && (err_q != '1)) err_d = err_q + CNT_W'(1);

    if (cfg_burst_len == '0)                         len_eff = BURST_W'(1);
    else if (cfg_burst_len > BURST_W'(MAX_BURST))    len_eff = BURST_W'(MAX_BURST);
    else                                             len_eff = cfg_burst_len;
  end

  // One generator serves both phases: loaded at start, rewound on entry to the read phase.
  hram_pattern_gen #(
    .W (DATA_W)
  ) u_pattern (
    .clk         (clk_clk),
    .rst_n       (reset_reset_n),
    .seed_load_i (start_acc),
    .seed_i      (cfg_seed),
    .reload_i    (wr_acc && last_beat && last_burst),
    .advance_i   (wr_acc || rd_beat),
    .word_o      (pat_word)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      first_err_q <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      nbursts_q   <= '0;
      burst_q     <= '0;
      err_q       <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_acc) begin
            base_q      <= base_eff;
            addr_q      <= base_eff;
            len_q       <= len_eff;
            nbursts_q   <= cfg_num_bursts;
            beat_q      <= '0;
            burst_q     <= '0;
            err_q       <= '0;
            first_err_q <= '0;
            if (cfg_num_bursts == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q <= ST_WR_BURST;
              write_q <= 1'b1;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              pass_q  <= 1'b0;
            end
          end
        end

        ST_WR_BURST: begin
          if (wr_acc) begin
            if (last_beat) begin
              beat_q <= '0;
              if (last_burst) begin
                state_q <= ST_RD_CMD;
                write_q <= 1'b0;
                read_q  <= 1'b1;
                addr_q  <= base_q;
                burst_q <= '0;
              end else begin
                addr_q  <= addr_q + burst_bytes;
                burst_q <= burst_q + CNT_W'(1);
              end
            end else begin
              beat_q <= beat_q + BURST_W'(1);
            end
          end
        end

        ST_RD_CMD: begin
          if (rd_acc) begin
            read_q  <= 1'b0;
            state_q <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (rd_beat) begin
            err_q <= err_d;
            // err_q is cleared at start and never returns to zero, so zero marks the first miss.
            if (mismatch && (err_q == '0)) first_err_q <= beat_addr;
            if (last_beat) begin
              beat_q <= '0;
              if (last_burst) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= (err_d == '0);
              end else begin
                state_q <= ST_RD_CMD;
                read_q  <= 1'b1;
                addr_q  <= addr_q + burst_bytes;
                burst_q <= burst_q + CNT_W'(1);
              end
            end else begin
              beat_q <= beat_q + BURST_W'(1);
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign avm_address    = addr_q;
  assign avm_read       = read_q;
  assign avm_write      = write_q;
  assign avm_writedata  = pat_word;
  assign avm_burstcount = len_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign error_count    = err_q;
  assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_avs_hram_burst_tester.sv
// Self-checking bench: behavioural HyperRAM slave plus write/read scoreboards for avs_hram_burst_tester.
module tb_avs_hram_burst_tester;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfg_base_addr = '0;
  logic [10:0] cfg_burst_len = '0;
  logic [15:0] cfg_num_bursts = '0;
  logic [15:0] cfg_seed = '0;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic [10:0] avm_burstcount;
  logic        avm_waitrequest = 1'b0;
  logic [15:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] error_count;
  logic [31:0] first_err_addr;

  avs_hram_burst_tester dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .start             (start),
    .cfg_base_addr     (cfg_base_addr),
    .cfg_burst_len     (cfg_burst_len),
    .cfg_num_bursts    (cfg_num_bursts),
    .cfg_seed          (cfg_seed),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_burstcount    (avm_burstcount),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .error_count       (error_count),
    .first_err_addr    (first_err_addr)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] baddr;
    logic [15:0] data;
    logic [10:0] bcnt;
  } wr_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [10:0] bcnt;
  } rd_exp_t;

  wr_exp_t     wr_q[$];
  rd_exp_t     rd_q[$];
  logic [15:0] mem [logic [31:0]];

  int n_vec = 0;
  int n_err = 0;

  bit          wr_wait_en = 1'b0;
  bit          rdv_gaps = 1'b0;
  int          corrupt_idx = -1;
  int          rd_pend = 0;
  int          rd_idx = 0;
  int          rd_beats_total = 0;
  int          bus_events = 0;
  logic [31:0] rd_addr = '0;
  bit          held_valid = 1'b0;
  logic [15:0] held_data = '0;
  logic [31:0] held_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pat_first(input logic [15:0] seed);
`ifdef HRAM_TESTER_LFSR_EN
    return (seed == 16'h0) ? 16'hACE1 : seed;
`else
    return seed;
`endif
  endfunction

  function automatic logic [15:0] pat_next(input logic [15:0] w);
`ifdef HRAM_TESTER_LFSR_EN
    return {1'b0, w[15:1]} ^ (w[0] ? 16'hB400 : 16'h0000);
`else
    return w + 16'h1;
`endif
  endfunction

  // Behavioural slave: decides waitrequest, returns read beats, and checks each accepted command.
  initial begin
    wr_exp_t     we;
    rd_exp_t     re;
    logic [31:0] ba;
    logic [15:0] word;
    forever begin
      @(negedge clk_clk);
      if (reset_reset_n) begin
        avm_readdatavalid = 1'b0;
        if (rd_pend > 0 && (!rdv_gaps || $urandom_range(3) != 0)) begin
          ba   = rd_addr + 32'(rd_idx * 2);
          word = mem.exists(ba) ? mem[ba] : 16'h0000;
          if (rd_beats_total == corrupt_idx) word = word ^ 16'h00FF;
          avm_readdata      = word;
          avm_readdatavalid = 1'b1;
          rd_idx++;
          rd_pend--;
          rd_beats_total++;
        end

        avm_waitrequest = wr_wait_en && avm_write && ($urandom_range(1) == 0);
        if (avm_write || avm_read) bus_events++;

        if (held_valid && avm_write) begin
          check("wr_hold_data", 32'(avm_writedata), 32'(held_data));
          check("wr_hold_addr", avm_address, held_addr);
        end
        held_valid = avm_write && avm_waitrequest;
        held_data  = avm_writedata;
        held_addr  = avm_address;

        if (avm_write && !avm_waitrequest) begin
          check("rw_excl_w", 32'(avm_read), 32'h0);
          if (wr_q.size() == 0) begin
            check("wr_extra", 32'(avm_write), 32'h0);
          end else begin
            we = wr_q.pop_front();
            check("wr_addr", avm_address, we.addr);
            check("wr_data", 32'(avm_writedata), 32'(we.data));
            check("wr_bcnt", 32'(avm_burstcount), 32'(we.bcnt));
            mem[we.baddr] = avm_writedata;
          end
        end

        if (avm_read && !avm_waitrequest) begin
          check("rw_excl_r", 32'(avm_write), 32'h0);
          check("rd_outstanding", 32'(rd_pend), 32'h0);
          if (rd_q.size() == 0) begin
            check("rd_extra", 32'(avm_read), 32'h0);
          end else begin
            re = rd_q.pop_front();
            check("rd_addr", avm_address, re.addr);
            check("rd_bcnt", 32'(avm_burstcount), 32'(re.bcnt));
          end
          rd_addr = avm_address;
          rd_pend = int'(avm_burstcount);
          rd_idx  = 0;
        end
      end else begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
      end
    end
  end

  task automatic check_reset_outs(input string tag);
    check({tag, "_addr"},  avm_address, 32'h0);
    check({tag, "_read"},  32'(avm_read), 32'h0);
    check({tag, "_write"}, 32'(avm_write), 32'h0);
    check({tag, "_wdata"}, 32'(avm_writedata), 32'h0);
    check({tag, "_bcnt"},  32'(avm_burstcount), 32'h0);
    check({tag, "_busy"},  32'(busy), 32'h0);
    check({tag, "_done"},  32'(done), 32'h0);
    check({tag, "_pass"},  32'(pass), 32'h0);
    check({tag, "_errs"},  32'(error_count), 32'h0);
    check({tag, "_ferr"},  first_err_addr, 32'h0);
  endtask

  // Pushes the expected command stream, pulses start and checks the first-cycle response.
  task automatic start_test(input logic [31:0] base, input logic [10:0] len, input logic [15:0] nb,
                            input logic [15:0] seed, input bit wwait, input bit gaps, input int corrupt);
    logic [31:0] a;
    logic [15:0] w;
    logic [15:0] w0;
    int          eff;
    int          ev0;
    eff = (len == 11'd0) ? 1 : ((len > 11'd1024) ? 1024 : int'(len));
    a   = base & ~32'h1;
    w0  = pat_first(seed);
    w   = w0;
    for (int b = 0; b < int'(nb); b++) begin
      rd_q.push_back('{addr: a, bcnt: 11'(eff)});
      for (int i = 0; i < eff; i++) begin
        wr_q.push_back('{addr: a, baddr: a + 32'(i * 2), data: w, bcnt: 11'(eff)});
        w = pat_next(w);
      end
      a = a + 32'(eff * 2);
    end
    wr_wait_en     = wwait;
    rdv_gaps       = gaps;
    corrupt_idx    = corrupt;
    rd_beats_total = 0;

    @(negedge clk_clk);
    cfg_base_addr  = base;
    cfg_burst_len  = len;
    cfg_num_bursts = nb;
    cfg_seed       = seed;
    start          = 1'b1;
    ev0            = bus_events;
    @(negedge clk_clk);
    start = 1'b0;
    if (nb == 16'd0) begin
      check("zero_done", 32'(done), 32'h1);
      check("zero_pass", 32'(pass), 32'h1);
      check("zero_busy", 32'(busy), 32'h0);
      repeat (4) @(negedge clk_clk);
      check("zero_bus", 32'(bus_events - ev0), 32'h0);
    end else begin
      check("lat_write", 32'(avm_write), 32'h1);
      check("lat_busy", 32'(busy), 32'h1);
      check("lat_done", 32'(done), 32'h0);
      check("first_wdata", 32'(avm_writedata), 32'(w0));
    end
  endtask

  task automatic finish_test(input logic [15:0] exp_err, input logic [31:0] exp_first);
    for (int c = 0; c < 4000 && !done; c++) @(negedge clk_clk);
    check("end_done", 32'(done), 32'h1);
    check("end_busy", 32'(busy), 32'h0);
    check("end_pass", 32'(pass), (exp_err == 16'd0) ? 32'h1 : 32'h0);
    check("end_errs", 32'(error_count), 32'(exp_err));
    check("end_ferr", first_err_addr, exp_first);
    check("end_wr_left", 32'(wr_q.size()), 32'h0);
    check("end_rd_left", 32'(rd_q.size()), 32'h0);
    check("end_bus_idle", 32'({avm_read, avm_write}), 32'h0);
  endtask

  initial begin
    #3;
    check_reset_outs("rst");
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    check_reset_outs("post_rst");

    start_test(32'h0000_0100, 11'd4, 16'd2, 16'h1000, 1'b0, 1'b0, -1);
    finish_test(16'd0, 32'h0);

    start_test(32'h0000_2000, 11'd6, 16'd3, 16'hBEEF, 1'b1, 1'b1, -1);
    finish_test(16'd0, 32'h0);

    start_test(32'h0000_0200, 11'd8, 16'd1, 16'h0042, 1'b0, 1'b0, 5);
    finish_test(16'd1, 32'h0000_020A);

    start_test(32'h0000_0500, 11'd4, 16'd0, 16'h1234, 1'b0, 1'b0, -1);
    finish_test(16'd0, 32'h0);

    start_test(32'h0000_0301, 11'd0, 16'd3, 16'h7FFF, 1'b0, 1'b0, -1);
    finish_test(16'd0, 32'h0);

    start_test(32'hFFFF_FFFC, 11'd4, 16'd2, 16'hFFFE, 1'b1, 1'b0, -1);
    finish_test(16'd0, 32'h0);

    start_test(32'h0000_0400, 11'd3, 16'd1, 16'h0000, 1'b0, 1'b0, -1);
    finish_test(16'd0, 32'h0);

    // Reset while a read burst is half delivered, then rerun from IDLE.
    start_test(32'h0000_0600, 11'd8, 16'd2, 16'h5A00, 1'b0, 1'b0, -1);
    for (int c = 0; c < 2000 && rd_beats_total < 3; c++) @(negedge clk_clk);
    check("rd_reached", 32'(rd_beats_total >= 3), 32'h1);
    #2;
    reset_reset_n = 1'b0;
    #1;
    check_reset_outs("mid_rst");
    rd_pend           = 0;
    avm_readdatavalid = 1'b0;
    held_valid        = 1'b0;
    wr_q.delete();
    rd_q.delete();
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    start_test(32'h0000_0600, 11'd8, 16'd2, 16'h5A00, 1'b0, 1'b1, -1);
    finish_test(16'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
